conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming K×K sliding-window generator for the image convolution datapath. It accepts a raster-order pixel stream over a valid/ready handshake and buffers K-1 previous image lines internally. For every pixel position where a full K×K neighbourhood exists (valid-only borders, no padding), it emits one window. Frame geometry is runtime-configurable up to a compile-time maximum line width, and the output handshake supports backpressure.

## Interface
- B, 8: pixel width in bits
- K, 3: window size (odd, ≥3)
- W_MAX, 640: maximum line width in pixels
- HW, 12: width of the cfg_width and cfg_height fields
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- cfg_width  in  HW  line width in pixels, sampled on an accepted SOF pixel
- cfg_height  in  HW  frame height in lines, sampled on an accepted SOF pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel ready
- s_data  in  B  input pixel
- s_sof  in  1  marks the first pixel of a frame, qualified by s_valid
- m_valid  out  1  window valid
- m_ready  in  1  window accepted by downstream
- m_win  out  B × K*K  window, unpacked array
- m_eol  out  1  window is the last window of an output row
- m_eof  out  1  window is the last window of the frame
- err  out  1  sticky flag: last SOF carried an illegal configuration

## Operation
- Accept condition: a pixel is accepted when s_valid && s_ready. s_ready = !m_valid || m_ready, combinational.
- States:
  - IDLE: s_ready follows the rule above. Accepted pixels without s_sof are dropped.
  - RUN: active frame in progress.
- SOF handling (any state): accepting a pixel with s_sof latches W = cfg_width and H = cfg_height, then resets col and row to 0.
  - Legal config is K ≤ W ≤ W_MAX and K ≤ H. It clears err, moves to RUN, and processes the pixel as (0,0).
  - Illegal config sets err, moves to IDLE, and drops the pixel.
- Per accepted pixel in RUN, at column col:
  - Build column vector v: v[K-1] = s_data; v[r] = lb[r][col] for r < K-1. lb[K-2] holds the previous line; lb[0] holds the oldest line.
  - Write lb[r][col] ← v[r+1] for r < K-1.
  - Shift the window register left by one column and load v into the rightmost column.
  - Increment col. When col = W-1, wrap col to 0 and increment row.
- Window layout: m_win[r*K+c], r = 0 is the top (oldest) row, c = 0 is the leftmost column. m_win[K*K-1] is the newest pixel; the centre is index (K*K-1)/2.
- Emission: a pixel at (row, col) with row ≥ K-1 and col ≥ K-1 sets m_valid on the next edge. This yields (W-K+1)·(H-K+1) windows per frame.
  - m_eol = (col == W-1).
  - m_eof = (col == W-1 && row == H-1).
- After the eof pixel is accepted, the state returns to IDLE. Further non-SOF pixels are dropped.
- SOF mid-frame (RUN): the frame restarts immediately. Partially buffered lines are discarded logically, because outputs are gated by the counters. A pending m_valid window is held until accepted.
- Line buffers (K-1 × W_MAX × B) are not reset and may infer RAM read-before-write. Stale contents are never exposed because of the emission gating.

## Timing
- Reset values:
  - m_valid 0, m_win all 0, m_eol 0, m_eof 0, err 0.
  - s_ready 1, state IDLE, col 0, row 0.
- Latency: 1 cycle from the accepting edge to m_valid/m_win.
- Throughput: one pixel and one window per cycle with m_ready held high.
- Backpressure: while m_valid && !m_ready, s_ready is 0, and m_win, m_eol, m_eof hold stable. No pixel is accepted and no state changes.
- m_valid clears on m_valid && m_ready, unless a new window is produced on the same edge.
- Reset mid-frame returns all outputs to their reset values on the asynchronous edge. The next frame must start with SOF.

## Test plan
- Basic frame. K=3, W=4, H=4, pixels 0..15 with SOF on pixel 0, m_ready=1. Expect exactly 4 windows:
  - first window = {0,1,2, 4,5,6, 8,9,10};
  - m_eol on the 2nd and 4th windows;
  - last window = {5,6,7, 9,10,11, 13,14,15} with m_eof=1;
  - state returns to IDLE.
- Backpressure. Same frame with m_ready low for 5 cycles when the first window appears. Expect s_ready=0 for those 5 cycles, m_win held at {0,1,2,4,5,6,8,9,10}, and the total window count still 4.
- Mid-frame SOF. After 7 pixels of a W=4 frame, assert SOF with W=5, H=3 and send pixels 100..114. Expect exactly 3 windows, the first = {100,101,102, 105,106,107, 110,111,112}, with no mix of old data.
- Illegal config. SOF with W=2 (or W=W_MAX+1). Expect err=1, no m_valid for the following 16 pixels, s_ready=1. A legal SOF afterwards clears err.
- Reset mid-frame. Assert rstn=0 with m_valid=1. Expect all outputs at reset values immediately; non-SOF pixels afterwards are dropped.
- Maximum width. W=W_MAX, H=K with random pixels, compared against a reference model. Expect W_MAX-K+1 windows and exactly one m_eof.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Handshake/bus bundle for conv_window_gen.
//   cfg_width/cfg_height : frame geometry, sampled on an accepted SOF pixel
//   s_valid/s_ready/s_data/s_sof : raster pixel stream into the generator
//   m_valid/m_ready/m_win/m_eol/m_eof : K*K window stream out of the generator
//   err : sticky illegal-configuration flag
// master = pixel producer / window consumer side, slave = the generator.
interface conv_window_gen_if #(
  parameter int B  = 8,
  parameter int K  = 3,
  parameter int HW = 12
);
  logic [HW-1:0] cfg_width;
  logic [HW-1:0] cfg_height;
  logic          s_valid;
  logic          s_ready;
  logic [B-1:0]  s_data;
  logic          s_sof;
  logic          m_valid;
  logic          m_ready;
  logic [B-1:0]  m_win [K*K];
  logic          m_eol;
  logic          m_eof;
  logic          err;

  modport master (
    output cfg_width, cfg_height, s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_win, m_eol, m_eof, err
  );

  modport slave (
    input  cfg_width, cfg_height, s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_win, m_eol, m_eof, err
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator.
// Buffers K-1 previous lines and emits one window for every pixel position
// that has a full KxK neighbourhood (valid-only borders, no padding).
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : conv_window_gen_if.slave (config, pixel stream in, window stream out, err)
module conv_window_gen #(
  parameter int B     = 8,
  parameter int K     = 3,
  parameter int W_MAX = 640,
  parameter int HW    = 12
) (
  input  logic              clk,
  input  logic              rstn,
  conv_window_gen_if.slave  bus
);
  localparam int            CW      = $clog2(W_MAX);
  localparam logic [HW-1:0] ONE     = HW'(1);
  localparam logic [HW-1:0] K_HW    = HW'(K);
  localparam logic [HW-1:0] KM1_HW  = HW'(K - 1);
  localparam logic [HW-1:0] WMAX_HW = HW'(W_MAX);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] w_q, w_d, h_q, h_d;
  logic [HW-1:0] col_q, col_d, row_q, row_d;
  logic [B-1:0]  win_q [K][K];
  logic [B-1:0]  win_d [K][K];
  logic          m_valid_q, m_valid_d;
  logic          m_eol_q, m_eol_d;
  logic          m_eof_q, m_eof_d;
  logic          err_q, err_d;

  // lb_mem[K-2] is the previous line, lb_mem[0] the oldest one.
  logic [B-1:0]  lb_mem [K-1][W_MAX];

  logic          accept, legal, proc, emit, last_col, last_row;
  logic [HW-1:0] cur_col, cur_row, cur_w, cur_h;
  logic [B-1:0]  v [K];

  assign bus.s_ready = !m_valid_q || bus.m_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    m_valid_d = m_valid_q;
    m_eol_d   = m_eol_q;
    m_eof_d   = m_eof_q;
    err_d     = err_q;

    accept = bus.s_valid && bus.s_ready;
    legal  = (bus.cfg_width >= K_HW) && (bus.cfg_width <= WMAX_HW) &&
             (bus.cfg_height >= K_HW);

    // An SOF pixel is processed as (0,0) of the newly latched geometry.
    cur_col = bus.s_sof ? '0 : col_q;
    cur_row = bus.s_sof ? '0 : row_q;
    cur_w   = bus.s_sof ? bus.cfg_width  : w_q;
    cur_h   = bus.s_sof ? bus.cfg_height : h_q;

    proc     = accept && (bus.s_sof ? legal : (state_q == RUN));
    last_col = (cur_col == cur_w - ONE);
    last_row = (cur_row == cur_h - ONE);
    // Counter gating is what keeps stale line-buffer data and leftovers of an
    // aborted frame from ever reaching the output.
    emit     = proc && (cur_row >= KM1_HW) && (cur_col >= KM1_HW);

    for (int r = 0; r < K - 1; r++) v[r] = lb_mem[r][cur_col[CW-1:0]];
    v[K-1] = bus.s_data;

    if (accept && bus.s_sof) begin
      w_d     = bus.cfg_width;
      h_d     = bus.cfg_height;
      col_d   = '0;
      row_d   = '0;
      err_d   = !legal;
      state_d = legal ? RUN : IDLE;
    end

    if (proc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = v[r];
      end
      if (last_col) begin
        col_d = '0;
        row_d = cur_row + ONE;
        if (last_row) state_d = IDLE;
      end else begin
        col_d = cur_col + ONE;
      end
    end

    if (emit) begin
      m_valid_d = 1'b1;
      m_eol_d   = last_col;
      m_eof_d   = last_col && last_row;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_eol_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_eol_q   <= m_eol_d;
      m_eof_q   <= m_eof_d;
      err_q     <= err_d;
      win_q     <= win_d;
    end
  end

  // NOTE: line buffers are deliberately left unreset so they can map to RAM.
  always_ff @(posedge clk) begin
    if (proc) begin
      for (int r = 0; r < K - 1; r++) lb_mem[r][cur_col[CW-1:0]] <= v[r+1];
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) bus.m_win[r*K+c] = win_q[r][c];
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_eol   = m_eol_q;
  assign bus.m_eof   = m_eof_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (K=3, W_MAX=640).
module tb_conv_window_gen;
  localparam int B = 8, K = 3, W_MAX = 640, HW = 12;

  typedef struct packed {
    logic [71:0] w;   // m_win[0] in the top byte, m_win[8] in the bottom byte
    logic        eol;
    logic        eof;
  } win_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.B(B), .K(K), .HW(HW)) bus();

  conv_window_gen #(.B(B), .K(K), .W_MAX(W_MAX), .HW(HW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  win_t cap_q[$];
  win_t exp_basic [4];
  win_t exp_mid   [3];
  logic [7:0] img [3*W_MAX];

  function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
  endfunction

  function automatic win_t cur_win();
    win_t t;
    for (int i = 0; i < 9; i++) t.w[(8-i)*8 +: 8] = bus.m_win[i];
    t.eol = bus.m_eol;
    t.eof = bus.m_eof;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Windows are recorded on the negedge before the handshaking posedge.
  always @(negedge clk) begin
    if (rstn && bus.m_valid && bus.m_ready) cap_q.push_back(cur_win());
  end

  task automatic send(input logic [7:0] d, input logic sof);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    @(negedge clk);
    while (!bus.s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stuck low for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int base, input int n);
    bus.cfg_width  = HW'(w);
    bus.cfg_height = HW'(h);
    for (int i = 0; i < n; i++) send(8'(base + i), i == 0);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cmp_table_basic(input string tag);
    check({tag, "_count"}, cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++)
      check($sformatf("%s_win%0d", tag, i), cap_q[i], exp_basic[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int eofs;
    win_t e;

    exp_basic[0] = '{w: w9(0,1,2, 4,5,6, 8,9,10),      eol: 1'b0, eof: 1'b0};
    exp_basic[1] = '{w: w9(1,2,3, 5,6,7, 9,10,11),     eol: 1'b1, eof: 1'b0};
    exp_basic[2] = '{w: w9(4,5,6, 8,9,10, 12,13,14),   eol: 1'b0, eof: 1'b0};
    exp_basic[3] = '{w: w9(5,6,7, 9,10,11, 13,14,15),  eol: 1'b1, eof: 1'b1};
    exp_mid[0]   = '{w: w9(100,101,102, 105,106,107, 110,111,112), eol: 1'b0, eof: 1'b0};
    exp_mid[1]   = '{w: w9(101,102,103, 106,107,108, 111,112,113), eol: 1'b0, eof: 1'b0};
    exp_mid[2]   = '{w: w9(102,103,104, 107,108,109, 112,113,114), eol: 1'b1, eof: 1'b1};

    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.s_sof      = 1'b0;
    bus.m_ready    = 1'b1;

    // Reset values
    #2 rstn = 1'b0;
    #3;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_eol",   bus.m_eol, 0);
    check("rst_m_eof",   bus.m_eof, 0);
    check("rst_err",     bus.err, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_win",   cur_win().w, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Basic frame
    cap_q.delete();
    send_frame(4, 4, 0, 16);
    drain();
    cmp_table_basic("basic");

    // Back in IDLE: non-SOF pixels are dropped
    cap_q.delete();
    for (int i = 0; i < 16; i++) send(8'(50 + i), 1'b0);
    drain();
    check("idle_drop_count", cap_q.size(), 0);

    // Backpressure on the first window
    cap_q.delete();
    bus.m_ready = 1'b0;
    fork
      send_frame(4, 4, 0, 16);
      begin
        n = 0;
        @(negedge clk);
        while (!bus.m_valid && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("bp_first_valid", bus.m_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check($sformatf("bp_s_ready_%0d", i), bus.s_ready, 0);
          check($sformatf("bp_hold_%0d", i), cur_win(), exp_basic[0]);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
      end
    join
    drain();
    cmp_table_basic("bp");

    // Mid-frame SOF restart
    cap_q.delete();
    send_frame(4, 4, 0, 7);
    send_frame(5, 3, 100, 15);
    drain();
    check("mid_count", cap_q.size(), 3);
    for (int i = 0; i < 3 && i < cap_q.size(); i++)
      check($sformatf("mid_win%0d", i), cap_q[i], exp_mid[i]);

    // Illegal configurations
    cap_q.delete();
    send_frame(2, 4, 0, 1);
    check("ill_w2_err", bus.err, 1);
    for (int i = 0; i < 16; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i);
      @(negedge clk);
      check($sformatf("ill_ready_%0d", i), bus.s_ready, 1);
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
    end
    drain();
    check("ill_no_windows", cap_q.size(), 0);
    send_frame(W_MAX + 1, 4, 0, 1);
    check("ill_wmax_err", bus.err, 1);
    send_frame(3, 3, 200, 9);
    check("legal_clears_err", bus.err, 0);
    drain();
    check("legal_after_ill_count", cap_q.size(), 1);

    // Reset mid-frame with a window pending
    cap_q.delete();
    bus.m_ready = 1'b0;
    send_frame(4, 4, 0, 11);
    @(negedge clk);
    check("rmid_pending_valid", bus.m_valid, 1);
    #1 rstn = 1'b0;
    #1;
    check("rmid_m_valid", bus.m_valid, 0);
    check("rmid_m_eol",   bus.m_eol, 0);
    check("rmid_m_eof",   bus.m_eof, 0);
    check("rmid_err",     bus.err, 0);
    check("rmid_s_ready", bus.s_ready, 1);
    check("rmid_m_win",   cur_win().w, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    drain();
    check("rmid_drop_count", cap_q.size(), 0);

    // Maximum width, random pixels, reference model
    cap_q.delete();
    for (int i = 0; i < 3 * W_MAX; i++) img[i] = 8'($urandom_range(0, 255));
    bus.cfg_width  = HW'(W_MAX);
    bus.cfg_height = HW'(K);
    for (int i = 0; i < 3 * W_MAX; i++) send(img[i], i == 0);
    drain();
    check("maxw_count", cap_q.size(), W_MAX - K + 1);
    eofs = 0;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i].eof) eofs++;
    check("maxw_eof_count", eofs, 1);
    for (int i = 0; i < W_MAX - K + 1 && i < cap_q.size(); i++) begin
      int c;
      c = i + 2;
      e.w   = w9(img[c-2], img[c-1], img[c],
                 img[W_MAX+c-2], img[W_MAX+c-1], img[W_MAX+c],
                 img[2*W_MAX+c-2], img[2*W_MAX+c-1], img[2*W_MAX+c]);
      e.eol = (c == W_MAX - 1);
      e.eof = (c == W_MAX - 1);
      check($sformatf("maxw_win%0d", i), cap_q[i], e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
